// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets (address[3:2]) of the 16-byte window
//   - STATUS register bit positions
//   - transmit FSM state encoding
//   - minimum baud divisor and a helper that enforces it
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 2;
  localparam int STAT_OVERFLOW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divisor of 0 or 1 would make a bit last less than the counter can
  // express, so the smallest usable divisor is 2.
  localparam logic [15:0] MIN_DIV = 16'd2;

  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio_if
// Core memory bus as seen by the UART register window. No wait states:
// every access completes in the cycle it is presented.
//   memory_read   read strobe from core
//   memory_write  write strobe from core
//   address       byte address from core
//   write_data    store data from core
//   read_data     load data to core (combinational in the slave)
// ---------------------------------------------------------------------------
interface uart_tx_mmio_if;

  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output memory_read, memory_write, address, write_data,
    input  read_data
  );

  modport slave (
    input  memory_read, memory_write, address, write_data,
    output read_data
  );

endinterface

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous byte FIFO, first-word-fall-through (dout shows the head entry
// whenever empty is low).
//   clk, reset  clock and synchronous active-high reset
//   push, din   write request and byte; ignored while full
//   pop         read request; ignored while empty
//   dout        head entry
//   full, empty occupancy flags
// FIFO_DEPTH must be a power of two and at least 2 so pointers wrap freely.
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and count define which entries are valid, and a reset-free array maps
  // onto plain RAM/flops without a wide reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state is always updated with non-blocking assignments
  // so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter (LSB first) with a small TX FIFO.
//   clk, reset  clock and synchronous active-high reset
//   bus         slave side of the core memory bus (uart_tx_mmio_if)
//   tx          registered serial output, idle high
// Register window (address[3:2]) at BASE_ADDRESS:
//   0 TXDATA  W  push write_data[7:0]; reads 0
//   1 STATUS  R  {overflow, empty, full, busy}; any write clears overflow
//   2 BAUDDIV RW divisor in bits[15:0], written values below 2 become 2
//   3 -          reads 0, writes ignored
// ---------------------------------------------------------------------------
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000,
  parameter int          CLK_FREQ     = 25000000,
  parameter int          BAUD_RATE    = 115200,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);

  localparam logic [15:0] RESET_DIV = 16'(CLK_FREQ / BAUD_RATE);

  logic        sel;
  logic [1:0]  offset;
  logic        wr_en;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        bit_end;
  logic        busy;
  logic [31:0] read_data;
  logic        unused_bits;

  logic [15:0] baud_div_q;
  logic        overflow_q;
  tx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic [15:0] baud_cnt_q;
  logic [15:0] div_act_q;
  logic        tx_q;

  assign sel    = (bus.address[31:4] == BASE_ADDRESS[31:4]);
  assign offset = bus.address[3:2];
  assign wr_en  = bus.memory_write && sel;
  assign push   = wr_en && (offset == OFF_TXDATA);
  assign busy   = (state_q != ST_IDLE);

  // Byte lanes and low address bits the register map never looks at.
  assign unused_bits = ^{bus.address[1:0], bus.write_data[31:16]};

  // The frame uses the divisor latched at its start, so BAUDDIV writes
  // mid-frame only affect later frames.
  assign bit_end = (baud_cnt_q == div_act_q - 16'd1);

  // Pop in IDLE, or at the very end of a stop bit so the next start bit
  // follows with no idle gap.
  assign pop = !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

  uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register writes. A push while full is dropped inside the FIFO and only
  // leaves its trace here as the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div_q <= RESET_DIV;
      overflow_q <= 1'b0;
    end else if (wr_en) begin
      case (offset)
        OFF_TXDATA:  if (fifo_full) overflow_q <= 1'b1;
        OFF_STATUS:  overflow_q <= 1'b0;
        OFF_BAUDDIV: baud_div_q <= clamp_div(bus.write_data[15:0]);
        default:     ;
      endcase
    end
  end

  // Transmit FSM; tx is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      div_act_q  <= RESET_DIV;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q    <= fifo_dout;
            div_act_q  <= baud_div_q;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            tx_q       <= shift_q[0];
            state_q    <= ST_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            shift_q    <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              // shift_q[1] is the bit that shift_q[0] becomes after the shift.
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shift_q   <= fifo_dout;
              div_act_q <= baud_div_q;
              bit_idx_q <= '0;
              tx_q      <= 1'b0;
              state_q   <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: read_data gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    read_data = '0;
    if (bus.memory_read && sel) begin
      case (offset)
        OFF_STATUS: begin
          read_data[STAT_BUSY]     = busy;
          read_data[STAT_FULL]     = fifo_full;
          read_data[STAT_EMPTY]    = fifo_empty;
          read_data[STAT_OVERFLOW] = overflow_q;
        end
        OFF_BAUDDIV: read_data[15:0] = baud_div_q;
        default:     ;
      endcase
    end
  end

  assign bus.read_data = read_data;
  assign tx            = tx_q;

endmodule
